pfs32pipe: RTL and testbench

Three-stage pipelined IEEE-754 single-precision subtractor computing Diff = A − B, with a valid strobe travelling alongside the data. It is the inverse-operation companion to the pipelined FP32 adder: it uses the same clock, the same reset and the same operand format. It accepts one operand pair per cycle and produces status flags. Denormal inputs are flushed to zero. Results are rounded to nearest, ties to even.

---
 rtl/pfa_pkg.sv | 40 ++++
 rtl/lzc28.sv | 15 +
 rtl/pfs32pipe.sv | 197 +++++++++++++++++++
 tb/tb_pfs32pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pfa_pkg.sv
// Shared FP32 format constants and pipeline register layouts for the
// pipelined FP32 adder/subtractor pair.
package pfa_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIG_W    = 24;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_big;
        logic [SIG_W-1:0] sig_small;
        logic [4:0]       shamt;
        logic             eff_sub;
        logic             special;
        logic [31:0]      bypass;
        logic             bypass_inv;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [27:0]      sum;
        logic             special;
        logic [31:0]      bypass;
        logic             bypass_inv;
    } s2_t;

    // Hidden-1 insertion; a zero exponent field (zero or denormal) flushes to 0.
    function automatic logic [SIG_W-1:0] unpack_sig(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
    endfunction

endpackage

// File: rtl/lzc28.sv
// Combinational 28-bit leading-zero counter; an all-zero input gives 28.
module lzc28 (
    input  logic [27:0] i_data,
    output logic [4:0]  o_count
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        o_count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            o_count = i_data[i] ? 5'(27 - i) : o_count;
        end
    end

endmodule

// File: rtl/pfs32pipe.sv
// Three-stage pipelined FP32 subtractor, Diff = A - B, round to nearest even,
// denormals flushed to zero.
module pfs32pipe
    import pfa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        valid_out,
    output logic [31:0] Diff,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    logic [2:0]  r_valid;
    s1_t         r_s1;
    s2_t         r_s2;
    logic [31:0] r_diff;
    logic        r_invalid;
    logic        r_overflow;
    logic        r_underflow;

    logic [31:0] w_bn;
    logic [30:0] w_ka;
    logic [30:0] w_kb;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_nan;
    logic        w_b_nan;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_d;
    s1_t         w_s1;

    // Stage 1: negate B, classify, order by magnitude, resolve specials.
    always_comb begin
        w_bn    = {~B[31], B[30:0]};
        w_ka    = (A[30:23] == 8'd0) ? 31'd0 : A[30:0];
        w_kb    = (B[30:23] == 8'd0) ? 31'd0 : B[30:0];
        w_a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        w_b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
        w_a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        w_b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
        if (w_kb > w_ka) begin
            w_big   = w_bn;
            w_small = A;
        end else begin
            w_big   = A;
            w_small = w_bn;
        end
        w_d = w_big[30:23] - w_small[30:23];

        w_s1.sign       = w_big[31];
        w_s1.exp        = w_big[30:23];
        w_s1.sig_big    = unpack_sig(w_big);
        w_s1.sig_small  = unpack_sig(w_small);
        w_s1.shamt      = (w_d > 8'd26) ? 5'd26 : w_d[4:0];
        w_s1.eff_sub    = A[31] ^ w_bn[31];
        w_s1.special    = 1'b0;
        w_s1.bypass     = 32'd0;
        w_s1.bypass_inv = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_s1.special    = 1'b1;
            w_s1.bypass     = QNAN;
            w_s1.bypass_inv = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            w_s1.special = 1'b1;
            if (w_s1.eff_sub) begin
                w_s1.bypass     = QNAN;
                w_s1.bypass_inv = 1'b1;
            end else begin
                w_s1.bypass = {A[31], POS_INF[30:0]};
            end
        end else if (w_a_inf) begin
            w_s1.special = 1'b1;
            w_s1.bypass  = {A[31], POS_INF[30:0]};
        end else if (w_b_inf) begin
            w_s1.special = 1'b1;
            w_s1.bypass  = {w_bn[31], POS_INF[30:0]};
        end else if ((w_ka == 31'd0) && (w_kb == 31'd0)) begin
            // Only (-0) + (-0) after negation keeps a negative zero.
            w_s1.special = 1'b1;
            w_s1.bypass  = {A[31] & w_bn[31], 31'd0};
        end else begin
            w_s1.special = 1'b0;
        end
    end

    logic [52:0] w_wide;
    logic [26:0] w_al;
    logic [26:0] w_big27;
    s2_t         w_s2;

    // Stage 2: align the smaller significand with G/R/S, then add or subtract.
    always_comb begin
        w_wide  = {r_s1.sig_small, 29'd0} >> r_s1.shamt;
        w_al    = {w_wide[52:27], w_wide[26] | (|w_wide[25:0])};
        w_big27 = {r_s1.sig_big, 3'd0};
        w_s2.sign       = r_s1.sign;
        w_s2.exp        = r_s1.exp;
        w_s2.special    = r_s1.special;
        w_s2.bypass     = r_s1.bypass;
        w_s2.bypass_inv = r_s1.bypass_inv;
        if (r_s1.eff_sub) begin
            w_s2.sum = {1'b0, w_big27} - {1'b0, w_al};
        end else begin
            w_s2.sum = {1'b0, w_big27} + {1'b0, w_al};
        end
    end

    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic [9:0]  w_e;
    logic [9:0]  w_ef;
    logic        w_rup;
    logic [24:0] w_rnd;
    logic [22:0] w_man;
    logic [31:0] w_diff;
    logic        w_inv;
    logic        w_ov;
    logic        w_un;

    lzc28 u_lzc (
        .i_data  (r_s2.sum),
        .o_count (w_lz)
    );

    // Stage 3: normalize so the hidden bit sits at bit 26, round, range-check.
    always_comb begin
        if (r_s2.sum[27]) begin
            w_norm = {r_s2.sum[27:2], r_s2.sum[1] | r_s2.sum[0]};
            w_e    = {2'b00, r_s2.exp} + 10'd1;
        end else begin
            w_norm = r_s2.sum[26:0] << (w_lz - 5'd1);
            w_e    = {2'b00, r_s2.exp} - {5'd0, w_lz} + 10'd1;
        end
        w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
        if (w_rnd[24]) begin
            w_ef  = w_e + 10'd1;
            w_man = 23'd0;
        end else begin
            w_ef  = w_e;
            w_man = w_rnd[22:0];
        end

        w_diff = 32'd0;
        w_inv  = 1'b0;
        w_ov   = 1'b0;
        w_un   = 1'b0;
        if (r_s2.special) begin
            w_diff = r_s2.bypass;
            w_inv  = r_s2.bypass_inv;
        end else if (r_s2.sum == 28'd0) begin
            w_diff = 32'd0;
        end else if (w_ef[9] || (w_ef == 10'd0)) begin
            w_diff = {r_s2.sign, 31'd0};
            w_un   = 1'b1;
        end else if (w_ef >= 10'd255) begin
            w_diff = {r_s2.sign, POS_INF[30:0]};
            w_ov   = 1'b1;
        end else begin
            w_diff = {r_s2.sign, w_ef[7:0], w_man};
        end
    end

    // Pipeline registers; data advances every cycle, valid rides alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 3'd0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_diff      <= 32'd0;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid     <= {r_valid[1:0], valid_in};
            r_s1        <= w_s1;
            r_s2        <= w_s2;
            r_diff      <= w_diff;
            r_invalid   <= w_inv;
            r_overflow  <= w_ov;
            r_underflow <= w_un;
        end
    end

    assign valid_out = r_valid[2];
    assign Diff      = r_diff;
    assign invalid   = r_invalid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pfs32pipe.sv
// Scoreboard bench for pfs32pipe: directed vectors push expectations,
// an independent monitor checks every valid_out against them.
module tb_pfs32pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        valid_out;
    logic [31:0] Diff;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    pfs32pipe dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .A         (A),
        .B         (B),
        .valid_out (valid_out),
        .Diff      (Diff),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] diff;
        logic [2:0]  flags;
        int          issue;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // flags order: {invalid, overflow, underflow}
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic [2:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        A = a;
        B = b;
        e.diff  = d;
        e.flags = fl;
        e.issue = cyc;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        A = 32'd0;
        B = 32'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain timeout pending", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (q.size() == 0) begin
                check("unexpected valid_out", 64'(valid_out), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("Diff", 64'(Diff), 64'(e.diff));
                check("flags", 64'({invalid, overflow, underflow}), 64'(e.flags));
                check("latency", 64'(cyc - e.issue), 64'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("reset valid_out", 64'(valid_out), 64'd0);
        check("reset Diff", 64'(Diff), 64'd0);
        check("reset flags", 64'({invalid, overflow, underflow}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // basic, single cycle
        send(32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000);
        idle();
        drain();

        // cancellation
        send(32'h4F000000, 32'h4F000000, 32'h00000000, 3'b000);
        send(32'h3E800000, 32'h3E800000, 32'h00000000, 3'b000);
        send(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
        idle();
        drain();

        // zero minuend inside a 4-deep back-to-back burst
        send(32'h00000000, 32'h3F800000, 32'hBF800000, 3'b000);
        send(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
        send(32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000);
        send(32'h80000000, 32'h00000000, 32'h80000000, 3'b000);
        idle();
        drain();

        // specials
        send(32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100);
        send(32'h7F800000, 32'hFF800000, 32'h7F800000, 3'b000);
        send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
        idle();
        drain();

        // overflow / underflow / tiny exact difference, with a bubble
        send(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010);
        idle();
        send(32'h00800001, 32'h00800000, 32'h00000000, 3'b001);
        send(32'h3F800001, 32'h3F800000, 32'h34000000, 3'b000);
        idle();
        drain();

        // reset mid-stream discards in-flight work
        send(32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000);
        send(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
        send(32'h4F000000, 32'h3F800000, 32'h4F000000, 3'b000);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        reset = 1'b1;
        q.delete();
        #1;
        check("midreset valid_out", 64'(valid_out), 64'd0);
        check("midreset Diff", 64'(Diff), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post-reset valid_out", 64'(valid_out), 64'd0);
            check("post-reset Diff", 64'(Diff), 64'd0);
        end
        send(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
